fir_result_fifo: RTL

- Sits directly downstream of the 16-tap FIR core and captures each filtered result, which the core presents as a one-cycle valid pulse with a 32-bit y.
- Buffers results in a DEPTH-entry first-word-fall-through FIFO and releases them to the consumer (host/streaming interface) over a valid/ready handshake.
- Tracks an overflow flag, a dropped-sample counter and the signed peak of accepted results, so software can detect lost outputs while the core is not back-pressurable.

---
 rtl/fir_result_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fir_result_fifo.sv
// fir_result_fifo
// Captures one-cycle result strobes from the 16-tap FIR core into a
// first-word-fall-through FIFO and hands them to a consumer over a
// valid/ready handshake. Because the core cannot be back-pressured, the
// block also keeps overflow / dropped-sample statistics and the signed
// peak of accepted results for software.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   one-cycle strobe: in_data holds a new FIR result
//   in_data    FIR result y (signed two's complement)
//   out_valid  FIFO non-empty, out_data is valid
//   out_ready  consumer accepts out_data this cycle
//   out_data   oldest stored entry
//   level      current occupancy, 0..DEPTH
//   full       level == DEPTH
//   overflow   sticky, at least one sample was dropped
//   drop_cnt   dropped-sample count, saturates at 255
//   peak       largest signed accepted in_data since the last clear
//   clr_stat   synchronous clear of overflow, drop_cnt and peak
module fir_result_fifo #(
   parameter int N     = 32,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic [AW:0]   level,
   output logic          full,
   output logic          overflow,
   output logic [7:0]    drop_cnt,
   output logic [N-1:0]  peak,
   input  logic          clr_stat
);

   localparam logic [N-1:0] MOST_NEG   = {1'b1, {(N-1){1'b0}}};
   localparam logic [AW:0]  LVL_ONE    = (AW+1)'(1);
   localparam logic [AW:0]  LVL_PENULT = (AW+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   logic [N-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic [AW:0]   level_nxt_s;
   state_t        state_r;
   state_t        state_nxt_s;
   logic          overflow_r;
   logic [7:0]    drop_cnt_r;
   logic [N-1:0]  peak_r;
   logic          pop_s;
   logic          push_s;
   logic          drop_s;

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign pop_s  = out_valid & out_ready;
   assign push_s = in_valid & (~full | pop_s);
   assign drop_s = in_valid & full & ~pop_s;

   assign out_data = mem_r[rd_ptr_r];
   assign level    = level_r;
   assign overflow = overflow_r;
   assign drop_cnt = drop_cnt_r;
   assign peak     = peak_r;

   // State register: occupancy class, pointers and level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= ST_EMPTY;
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         state_r <= state_nxt_s;
         level_r <= level_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
      end
   end

   // Next occupancy and next occupancy class.
   always_comb begin
      level_nxt_s = level_r;
      state_nxt_s = state_r;
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + 1'b1;
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - 1'b1;
      end else begin
         level_nxt_s = level_r;
      end
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               state_nxt_s = ST_PARTIAL;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_PARTIAL: begin
            if (push_s && !pop_s && (level_r == LVL_PENULT)) begin
               state_nxt_s = ST_FULL;
            end else if (pop_s && !push_s && (level_r == LVL_ONE)) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_PARTIAL;
            end
         end
         ST_FULL: begin
            if (pop_s && !push_s) begin
               state_nxt_s = ST_PARTIAL;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // Handshake flags decoded from the registered occupancy class only,
   // so in_valid never reaches out_valid combinationally.
   always_comb begin
      out_valid = 1'b0;
      full      = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            out_valid = 1'b0;
            full      = 1'b0;
         end
         ST_PARTIAL: begin
            out_valid = 1'b1;
            full      = 1'b0;
         end
         ST_FULL: begin
            out_valid = 1'b1;
            full      = 1'b1;
         end
         default: begin
            out_valid = 1'b0;
            full      = 1'b0;
         end
      endcase
   end

   // Storage write; contents need no reset since level gates visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Statistics; a clear wins over a same-cycle drop or peak update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         peak_r     <= MOST_NEG;
      end else if (clr_stat) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         peak_r     <= MOST_NEG;
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
               drop_cnt_r <= drop_cnt_r + 8'd1;
            end
         end
         if (push_s && ($signed(in_data) > $signed(peak_r))) begin
            peak_r <= in_data;
         end
      end
   end

endmodule
